// File: rtl/clock_mode_controller_if.sv
// Controller bundle: debounced buttons and packed time/alarm in,
// counter strobes, display controls and alarm out.
interface clock_mode_controller_if;
  logic        btn_mode;
  logic        btn_inc;
  logic        alarm_arm;
  logic [23:0] time_bcd;
  logic [23:0] alarm_bcd;
  logic        sec_en;
  logic        min_en;
  logic        hour_en;
  logic        sec_clr;
  logic        amin_en;
  logic        ahour_en;
  logic        disp_sel;
  logic [5:0]  blink_mask;
  logic [2:0]  mode;
  logic        alarm_out;

  modport master (
    output btn_mode, btn_inc, alarm_arm,
    output time_bcd, alarm_bcd,
    input  sec_en, min_en, hour_en, sec_clr,
    input  amin_en, ahour_en,
    input  disp_sel, blink_mask, mode, alarm_out
  );

  modport slave (
    input  btn_mode, btn_inc, alarm_arm,
    input  time_bcd, alarm_bcd,
    output sec_en, min_en, hour_en, sec_clr,
    output amin_en, ahour_en,
    output disp_sel, blink_mask, mode, alarm_out
  );
endinterface

// File: rtl/clock_mode_controller.sv
// Alarm-clock sequencer: 1 Hz prescaler, mode FSM, counter strobes, alarm.
// Define AUTO_REPEAT_EN for held-button auto-repeat in the set modes.
module clock_mode_controller #(
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned ALARM_SECS  = 60,
  parameter int unsigned REPEAT_DLY  = 50000000,
  parameter int unsigned REPEAT_RATE = 20000000
) (
  input logic clk,
  input logic rst_n,
  clock_mode_controller_if.slave bus
);
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned RW = $clog2(ALARM_SECS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] RING_LAST = RW'(ALARM_SECS - 1);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be at least 2");
  end
  if (ALARM_SECS < 1) begin : g_bad_ring
    $error("ALARM_SECS must be at least 1");
  end
  if (REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_rep
    $error("REPEAT_DLY and REPEAT_RATE must be at least 1");
  end

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HOUR = 3'd1,
    SET_MIN  = 3'd2,
    AL_HOUR  = 3'd3,
    AL_MIN   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q;
  logic          blink_q;
  logic          btn_mode_q, btn_inc_q;
  logic          ring_q;
  logic [RW-1:0] ring_cnt_q;
  logic          sec_en_q, min_en_q, hour_en_q;
  logic          sec_clr_q, amin_en_q, ahour_en_q;

  logic tick, run, run_tick;
  logic mode_p, inc_p, rep_fire, inc_go;
  logic sec_wrap, min_wrap, sec_zero;
  logic ring_set, ring_clr, ring_end;
  logic [5:0] blink;

  assign tick     = (pre_q == PRE_LAST);
  assign run      = (state_q == RUN);
  assign run_tick = run && tick;
  assign mode_p   = bus.btn_mode && !btn_mode_q;
  assign inc_p    = bus.btn_inc && !btn_inc_q;
  assign inc_go   = (inc_p || rep_fire) && !mode_p;
  assign sec_wrap = (bus.time_bcd[7:0] == 8'h59);
  assign min_wrap = (bus.time_bcd[15:8] == 8'h59);
  assign sec_zero = (bus.time_bcd[7:0] == 8'h00);

`ifdef AUTO_REPEAT_EN
  logic [31:0] rep_cnt_q;
  logic        rep_on_q;
  logic        rep_hit;

  // First repeat after REPEAT_DLY, then every REPEAT_RATE while held
  assign rep_hit = bus.btn_inc && btn_inc_q &&
    (rep_on_q ? (rep_cnt_q == 32'(REPEAT_RATE))
              : (rep_cnt_q == 32'(REPEAT_DLY)));
  assign rep_fire = rep_hit && !run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
      rep_on_q  <= 1'b0;
    end else if (!bus.btn_inc) begin
      rep_cnt_q <= '0;
      rep_on_q  <= 1'b0;
    end else if (inc_p) begin
      rep_cnt_q <= 32'd1;
      rep_on_q  <= 1'b0;
    end else if (rep_hit) begin
      rep_cnt_q <= 32'd1;
      rep_on_q  <= 1'b1;
    end else begin
      rep_cnt_q <= rep_cnt_q + 32'd1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mode_p && !ring_q) state_d = SET_HOUR;
      SET_HOUR: if (mode_p) state_d = SET_MIN;
      SET_MIN:  if (mode_p) state_d = AL_HOUR;
      AL_HOUR:  if (mode_p) state_d = AL_MIN;
      AL_MIN:   if (mode_p) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pre_q      <= '0;
      blink_q    <= 1'b0;
      btn_mode_q <= 1'b0;
      btn_inc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= tick ? '0 : pre_q + 1'b1;
      blink_q    <= blink_q ^ tick;
      btn_mode_q <= bus.btn_mode;
      btn_inc_q  <= bus.btn_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_en_q   <= 1'b0;
      min_en_q   <= 1'b0;
      hour_en_q  <= 1'b0;
      sec_clr_q  <= 1'b0;
      amin_en_q  <= 1'b0;
      ahour_en_q <= 1'b0;
    end else begin
      sec_en_q   <= run_tick;
      min_en_q   <= (run_tick && sec_wrap) ||
                    (state_q == SET_MIN && inc_go);
      hour_en_q  <= (run_tick && sec_wrap && min_wrap) ||
                    (state_q == SET_HOUR && inc_go);
      sec_clr_q  <= (state_q == SET_MIN) && mode_p;
      amin_en_q  <= (state_q == AL_MIN) && inc_go;
      ahour_en_q <= (state_q == AL_HOUR) && inc_go;
    end
  end

  assign ring_set = run_tick && bus.alarm_arm && sec_zero &&
                    (bus.time_bcd[23:8] == bus.alarm_bcd[23:8]);
  assign ring_end = ring_q && tick && (ring_cnt_q == RING_LAST);
  assign ring_clr = (ring_q && run && mode_p) || !bus.alarm_arm ||
                    (state_d != RUN) || ring_end;

  // Clear beats set when both land in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
    end else if (ring_clr) begin
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
    end else if (ring_set) begin
      ring_q     <= 1'b1;
      ring_cnt_q <= '0;
    end else if (ring_q && tick) begin
      ring_cnt_q <= ring_cnt_q + 1'b1;
    end
  end

  always_comb begin
    blink = '0;
    if (blink_q) begin
      unique case (1'b1)
        state_q == SET_HOUR, state_q == AL_HOUR: blink = 6'b110000;
        state_q == SET_MIN, state_q == AL_MIN:   blink = 6'b001100;
        default:                                 blink = '0;
      endcase
    end
  end

  assign bus.sec_en     = sec_en_q;
  assign bus.min_en     = min_en_q;
  assign bus.hour_en    = hour_en_q;
  assign bus.sec_clr    = sec_clr_q;
  assign bus.amin_en    = amin_en_q;
  assign bus.ahour_en   = ahour_en_q;
  assign bus.disp_sel   = (state_q == AL_HOUR) || (state_q == AL_MIN);
  assign bus.blink_mask = blink;
  assign bus.mode       = state_q;
  assign bus.alarm_out  = ring_q;
endmodule

// File: tb/tb_clock_mode_controller.sv
// Bench for clock_mode_controller: cycle model compare plus directed checks.
// Define AUTO_REPEAT_EN on both RTL and bench to cover auto-repeat.
module tb_clock_mode_controller;
  localparam int TD = 4;
  localparam int AS = 60;
  localparam int RD = 10;
  localparam int RR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int ntests = 0;
  int nfail = 0;

  clock_mode_controller_if bus();

  clock_mode_controller #(
    .TICK_DIV(TD), .ALARM_SECS(AS),
    .REPEAT_DLY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: cycle counts and mode number as plain integers
  int n_cyc = 0, n_ticks = 0, md = 0, nm = 0;
  int ring_ticks = 0, hold = -1;
  bit p_mode = 0, p_inc = 0, ring = 0;
  bit tk, mp, ip, fire, go, s59, m59, aset, aclr;
  bit s_sec, s_min, s_hour, s_clr, s_amin, s_ahour;
  logic [5:0] bm;
  logic [16:0] exp_v = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_cyc = 0; n_ticks = 0; md = 0; ring_ticks = 0;
      hold = -1; p_mode = 0; p_inc = 0; ring = 0;
      exp_v = '0;
    end else begin
      tk = (n_cyc % TD) == TD - 1;
      n_cyc++;
      mp = bus.btn_mode && !p_mode;
      ip = bus.btn_inc && !p_inc;
      p_mode = bus.btn_mode;
      p_inc = bus.btn_inc;
      if (!bus.btn_inc) hold = -1;
      else if (ip) hold = 0;
      else hold++;
      fire = ip;
`ifdef AUTO_REPEAT_EN
      if (md != 0 && hold >= RD && (hold - RD) % RR == 0) fire = 1;
`endif
      go = fire && !mp;
      s59 = bus.time_bcd[7:0] == 8'h59;
      m59 = bus.time_bcd[15:8] == 8'h59;
      s_sec = md == 0 && tk;
      s_min = (s_sec && s59) || (md == 2 && go);
      s_hour = (s_sec && s59 && m59) || (md == 1 && go);
      s_clr = md == 2 && mp;
      s_amin = md == 4 && go;
      s_ahour = md == 3 && go;
      nm = md;
      if (mp && !(md == 0 && ring)) nm = (md + 1) % 5;
      aset = s_sec && bus.alarm_arm && bus.time_bcd[7:0] == 8'h00 &&
             bus.time_bcd[23:8] == bus.alarm_bcd[23:8];
      aclr = (md == 0 && mp && ring) || !bus.alarm_arm || nm != 0 ||
             (ring && tk && ring_ticks + 1 == AS);
      if (ring && tk) ring_ticks++;
      if (aclr) ring = 0;
      else if (aset) begin ring = 1; ring_ticks = 0; end
      if (tk) n_ticks++;
      md = nm;
      bm = 6'b0;
      if (n_ticks % 2 == 1) begin
        if (md == 1 || md == 3) bm = 6'b110000;
        if (md == 2 || md == 4) bm = 6'b001100;
      end
      exp_v = {s_sec, s_min, s_hour, s_clr, s_amin, s_ahour,
               md >= 3, bm, 3'(md), ring};
    end
  end

  logic [16:0] act_v;
  int c_sec = 0, c_min = 0, c_hour = 0;
  int c_clr = 0, c_amin = 0, c_ahour = 0;

  always @(negedge clk) begin
    act_v = {bus.sec_en, bus.min_en, bus.hour_en, bus.sec_clr,
             bus.amin_en, bus.ahour_en, bus.disp_sel,
             bus.blink_mask, bus.mode, bus.alarm_out};
    ntests++;
    if (act_v !== exp_v) begin
      nfail++;
      $display("FAIL model_cmp t=%0t act=%05h exp=%05h",
               $time, act_v, exp_v);
    end
    c_sec += int'(bus.sec_en);
    c_min += int'(bus.min_en);
    c_hour += int'(bus.hour_en);
    c_clr += int'(bus.sec_clr);
    c_amin += int'(bus.amin_en);
    c_ahour += int'(bus.ahour_en);
  end

  task automatic chk(input string name, input int act, input int expv);
    ntests++;
    if (act != expv) begin
      nfail++;
      $display("FAIL %s act=%0d exp=%0d", name, act, expv);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press_mode();
    step(1);
    bus.btn_mode = 1'b1;
    step(1);
    bus.btn_mode = 1'b0;
  endtask

  task automatic press_inc(input int held);
    step(1);
    bus.btn_inc = 1'b1;
    step(held);
    bus.btn_inc = 1'b0;
  endtask

  task automatic wait_ring(input string name);
    int k;
    k = 0;
    while (!bus.alarm_out && k < 10) begin
      step(1);
      k++;
    end
    chk(name, int'(bus.alarm_out), 1);
  endtask

  int s0, m0, h0, x0, len, on, off;
  logic [39:0] got, want;

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_inc = 1'b0;
    bus.alarm_arm = 1'b0;
    bus.time_bcd = 24'h125959;
    bus.alarm_bcd = 24'h000000;
    step(3);
    chk("rst_mode", int'(bus.mode), 0);
    chk("rst_sec_en", int'(bus.sec_en), 0);
    rst_n = 1'b1;

    s0 = c_sec; m0 = c_min; h0 = c_hour;
    step(14);
    chk("run_sec_en", c_sec - s0, 3);
    chk("run_min_en", c_min - m0, 3);
    chk("run_hour_en", c_hour - h0, 3);

    len = 0;
    while (!bus.sec_en && len < 8) begin
      step(1);
      len++;
    end
    chk("strobe_seen", int'(bus.sec_en), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid", int'({bus.sec_en, bus.min_en, bus.hour_en,
        bus.sec_clr, bus.amin_en, bus.ahour_en, bus.disp_sel,
        bus.blink_mask, bus.mode, bus.alarm_out}), 0);
    step(2);
    rst_n = 1'b1;

    press_mode();
    step(1);
    chk("mode_set_hour", int'(bus.mode), 1);
    s0 = c_sec; h0 = c_hour;
    press_inc(1);
    step(2);
    press_inc(1);
    step(2);
    press_inc(6);
    step(3);
    chk("set_hour_inc", c_hour - h0, 3);
    chk("set_hour_paused", c_sec - s0, 0);

    h0 = c_hour; m0 = c_min;
    step(1);
    bus.btn_mode = 1'b1;
    bus.btn_inc = 1'b1;
    step(1);
    bus.btn_mode = 1'b0;
    bus.btn_inc = 1'b0;
    step(2);
    chk("both_mode", int'(bus.mode), 2);
    chk("both_no_hour", c_hour - h0, 0);
    chk("both_no_min", c_min - m0, 0);

    h0 = c_hour; m0 = c_min;
    press_inc(1);
    step(2);
    chk("set_min_inc", c_min - m0, 1);
    chk("set_min_no_carry", c_hour - h0, 0);
    x0 = c_clr;
    press_mode();
    step(2);
    chk("sec_clr_once", c_clr - x0, 1);
    chk("mode_al_hour", int'(bus.mode), 3);
    chk("disp_alarm", int'(bus.disp_sel), 1);
    on = 0; off = 0;
    repeat (16) begin
      step(1);
      if (bus.blink_mask == 6'b110000) on++;
      if (bus.blink_mask == 6'b000000) off++;
    end
    chk("blink_on", on, 8);
    chk("blink_off", off, 8);

    x0 = c_ahour;
    press_inc(1);
    step(2);
    chk("al_hour_inc", c_ahour - x0, 1);
    press_mode();
    x0 = c_amin;
    press_inc(1);
    step(2);
    chk("al_min_inc", c_amin - x0, 1);
    press_mode();
    step(1);
    chk("back_run", int'(bus.mode), 0);
    chk("disp_time", int'(bus.disp_sel), 0);

    bus.alarm_bcd = 24'h063000;
    bus.time_bcd = 24'h063000;
    bus.alarm_arm = 1'b1;
    wait_ring("alarm_set");
    press_mode();
    chk("dismiss_alarm", int'(bus.alarm_out), 0);
    chk("dismiss_mode", int'(bus.mode), 0);

    wait_ring("alarm_reset");
    bus.time_bcd = 24'h063001;
    len = 1;
    while (len < 400) begin
      step(1);
      if (!bus.alarm_out) break;
      len++;
    end
    chk("alarm_len", len, AS * TD);

    bus.time_bcd = 24'h063000;
    wait_ring("alarm_again");
    bus.alarm_arm = 1'b0;
    step(1);
    chk("disarm_clear", int'(bus.alarm_out), 0);
    step(8);
    chk("disarm_quiet", int'(bus.alarm_out), 0);

`ifdef AUTO_REPEAT_EN
    press_mode();
    press_mode();
    step(1);
    chk("rep_mode", int'(bus.mode), 2);
    got = '0;
    want = '0;
    want[1] = 1'b1;
    want[11] = 1'b1;
    want[15] = 1'b1;
    want[19] = 1'b1;
    want[23] = 1'b1;
    want[27] = 1'b1;
    bus.btn_inc = 1'b1;
    for (int i = 1; i < 40; i++) begin
      step(1);
      got[i] = bus.min_en;
      if (i == 30) bus.btn_inc = 1'b0;
    end
    ntests++;
    if (got !== want) begin
      nfail++;
      $display("FAIL repeat_mask act=%h exp=%h", got, want);
    end
    press_mode();
    press_mode();
    press_mode();
    step(1);
    chk("rep_back_run", int'(bus.mode), 0);
`endif

    step(2);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule

// File: doc/clock_mode_controller.md
Name: clock_mode_controller

Overview:
- Sequencing controller for the alarm-clock time datapath: generates the 1 Hz tick and the increment/clear strobes for the second, minute and hour BCD counters and for the alarm minute/hour counters.
- Runs the user mode FSM (run, set time, set alarm), display source select and digit blink mask.
- Compares packed time against packed alarm and drives the alarm output.
- Sits between the debounced button/switch inputs and the counter and 24-bit packing stage that feed the seven-segment driver.

Parameters:
- TICK_DIV, 100000000: clk cycles per 1 Hz tick; must be at least 2.
- ALARM_SECS, 60: ticks the alarm rings before auto-off; must be at least 1.
- REPEAT_DLY, 50000000: cycles btn_inc is held before auto-repeat starts (AUTO_REPEAT_EN only).
- REPEAT_RATE, 20000000: cycles between auto-repeat pulses (AUTO_REPEAT_EN only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- btn_mode  in  1  debounced mode button, level
- btn_inc  in  1  debounced increment button, level
- alarm_arm  in  1  alarm enable switch, level
- time_bcd  in  24  packed current time {Hh,Hl,Mh,Ml,Sh,Sl}, 4-bit BCD per digit
- alarm_bcd  in  24  packed alarm time, same format; seconds digits ignored
- sec_en  out  1  one-cycle increment strobe to the seconds counter
- min_en  out  1  one-cycle increment strobe to the minutes counter
- hour_en  out  1  one-cycle increment strobe to the hours counter
- sec_clr  out  1  one-cycle synchronous clear strobe to the seconds counter
- amin_en  out  1  alarm minutes increment strobe
- ahour_en  out  1  alarm hours increment strobe
- disp_sel  out  1  display source: 0 = time, 1 = alarm
- blink_mask  out  6  per-digit blank, bit5 = Hh ... bit0 = Sl; 1 = blank
- mode  out  3  FSM state code
- alarm_out  out  1  alarm ringing

Behaviour:
Reset:
- rst_n low clears all state asynchronously: mode = RUN (0), prescaler = 0, blink phase = 0.
- All outputs are 0 during and after reset.
- Reset asserted mid-operation aborts any strobe, ring or set sequence. No strobe is issued on the reset release edge.

Prescaler:
- Counts 0 to TICK_DIV-1 and wraps. An internal tick is asserted in the wrap cycle.
- Runs in every mode.
- Blink phase toggles on each tick.

Button handling:
- Each button has a registered rising-edge detector producing a one-cycle press pulse.
- A held level produces exactly one pulse.

FSM:
- States: RUN = 0, SET_HOUR = 1, SET_MIN = 2, AL_HOUR = 3, AL_MIN = 4.
- A mode press advances RUN → SET_HOUR → SET_MIN → AL_HOUR → AL_MIN → RUN.
- Exception: a mode press in RUN while alarm_out = 1 only dismisses the alarm. The state does not change.
- Codes 5–7 are unreachable and return to RUN on the next cycle.

Strobes (all registered, asserted the cycle after their cause, one cycle wide):
- RUN, tick: sec_en = 1. Carries use time_bcd sampled in the tick cycle:
  - min_en = 1 if Sh:Sl == 5:9.
  - hour_en = 1 if Sh:Sl == 5:9 and Mh:Ml == 5:9.
  - The counters own their digit wrap, including 23 → 00.
- SET_HOUR: an inc press drives hour_en. Ticks are ignored, so time is paused.
- SET_MIN: an inc press drives min_en, with no carry into hours.
- Leaving SET_MIN: sec_clr pulses once, so seconds restart from 00.
- AL_HOUR: an inc press drives ahour_en.
- AL_MIN: an inc press drives amin_en.
- An inc press in RUN is ignored.
- A mode press and an inc press in the same cycle: the mode press wins and the inc is dropped.

Display:
- disp_sel = 1 in AL_HOUR and AL_MIN; 0 otherwise.
- blink_mask is 6'b110000 (SET_HOUR, AL_HOUR) or 6'b001100 (SET_MIN, AL_MIN) when blink phase = 1; 0 otherwise.
- blink_mask is always 0 in RUN.

Alarm:
- alarm_out sets on a RUN tick when alarm_arm = 1, time_bcd[23:8] == alarm_bcd[23:8], and Sh:Sl == 0:0 (time seconds). This fires once per matching minute.
- alarm_out clears on any of:
  - a dismiss press;
  - alarm_arm = 0 (next cycle);
  - leaving RUN;
  - ALARM_SECS ticks after it set.
- If a set condition and a clear condition coincide, the clear wins.

Optional Feature:
- AUTO_REPEAT_EN defined: in set states, holding btn_inc produces a strobe REPEAT_DLY cycles after the initial press, then every REPEAT_RATE cycles while held. Release stops repeating immediately.
- Undefined: one strobe per press only, and REPEAT_DLY/REPEAT_RATE are unused.

Test Plan:
1. Reset, TICK_DIV = 4, RUN, time_bcd = 0x125959 → sec_en, min_en and hour_en are all 1 in the cycle after each prescaler wrap; reset mid-strobe → all outputs 0.
2. Mode press ×1, three inc presses → mode = 1; hour_en pulses 3 times, one cycle each; no sec_en on ticks.
3. From SET_MIN, mode press → sec_clr pulses once and mode = 3; blink_mask alternates between 6'b110000 and 0 on successive ticks while disp_sel = 1.
4. Mode press and inc press in the same cycle in SET_HOUR → mode = 2; no hour_en.
5. alarm_arm = 1, alarm_bcd = 0x063000, time_bcd = 0x063000 on a RUN tick → alarm_out = 1; a mode press then clears alarm_out with mode staying 0; with no action, alarm_out clears after 60 ticks.
6. With AUTO_REPEAT_EN, REPEAT_DLY = 10, REPEAT_RATE = 4, hold inc for 30 cycles in SET_MIN → min_en at cycles 1, 11, 15, 19, 23, 27 relative to the press.
